// File: rtl/biu_sequencer_if.sv
// ---------------------------------------------------------------------------
// biu_sequencer_if
// Signal bundle for the Pine16 bus interface sequencer.
//   Requester side : req0/req1, rw0/rw1, adr0/adr1, dtw0/dtw1 (into sequencer)
//                    ack0/ack1, dtr0/dtr1, bus_err          (out of sequencer)
//   External bus   : bus_adr, bus_ale, bus_rd_n, bus_wr_n,
//                    bus_dout, bus_oe                        (out of sequencer)
//                    bus_din, bus_ready                      (into sequencer)
// modport slave  : the sequencer itself
// modport master : the environment (requesters plus bus slave)
// ---------------------------------------------------------------------------
interface biu_sequencer_if;
   logic        req0;
   logic        req1;
   logic        rw0;
   logic        rw1;
   logic [19:0] adr0;
   logic [19:0] adr1;
   logic [15:0] dtw0;
   logic [15:0] dtw1;
   logic        ack0;
   logic        ack1;
   logic [15:0] dtr0;
   logic [15:0] dtr1;
   logic        bus_err;
   logic [19:0] bus_adr;
   logic        bus_ale;
   logic        bus_rd_n;
   logic        bus_wr_n;
   logic [15:0] bus_dout;
   logic        bus_oe;
   logic [15:0] bus_din;
   logic        bus_ready;

   modport slave (
      input  req0, req1, rw0, rw1, adr0, adr1, dtw0, dtw1, bus_din, bus_ready,
      output ack0, ack1, dtr0, dtr1, bus_err,
      output bus_adr, bus_ale, bus_rd_n, bus_wr_n, bus_dout, bus_oe
   );

   modport master (
      output req0, req1, rw0, rw1, adr0, adr1, dtw0, dtw1, bus_din, bus_ready,
      input  ack0, ack1, dtr0, dtr1, bus_err,
      input  bus_adr, bus_ale, bus_rd_n, bus_wr_n, bus_dout, bus_oe
   );
endinterface

// File: rtl/biu_sequencer.sv
// ---------------------------------------------------------------------------
// biu_sequencer
// Arbitrates the instruction queue (port 0) and execution engine (port 1)
// onto the single 20-bit address / 16-bit data external bus and runs each
// granted transfer as a T1..T4 cycle with ready-driven wait states and a
// wait timeout. Read data and a one-cycle ack go back to the granted port.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bif   : biu_sequencer_if.slave (requester handshakes and external bus)
//
// Parameters:
//   WAIT_MAX   : T3 cycles with bus_ready low before forced termination
//   FAIR_LIMIT : consecutive port-1 grants tolerated while port 0 waits
//
// Build option:
//   BIU_FAIR_EN : when defined, a streak counter forces a port-0 grant after
//                 FAIR_LIMIT port-1 grants made while req0 was high.
//                 Undefined gives strict port-1 priority.
//
// All outputs are registers; nothing combinational reaches an output.
// ---------------------------------------------------------------------------
module biu_sequencer #(
   parameter int WAIT_MAX   = 15,
   parameter int FAIR_LIMIT = 4
) (
   input logic              clk,
   input logic              rst_n,
   biu_sequencer_if.slave   bif
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] T1   = 3'd1;
   localparam logic [2:0] T2   = 3'd2;
   localparam logic [2:0] T3   = 3'd3;
   localparam logic [2:0] T4   = 3'd4;

   logic [2:0]  state;
   logic        gnt;
   logic        lrw;
   logic [15:0] ldtw;
   logic [7:0]  wcnt;

   logic        take;
   logic        pick1;
   logic        tmo;
   logic [15:0] rdata;

   assign take = bif.req0 | bif.req1;

   // Timeout fires on the WAIT_MAX-th low-ready T3 cycle, so the counter
   // compares against WAIT_MAX-1 (it holds the number of earlier waits).
   assign tmo   = !bif.bus_ready && (wcnt == 8'(WAIT_MAX - 1));
   assign rdata = bif.bus_ready ? bif.bus_din : 16'hFFFF;

`ifdef BIU_FAIR_EN
   logic [3:0] streak;
   logic       force0;

   assign force0 = bif.req0 && (streak == 4'(FAIR_LIMIT));
   assign pick1  = bif.req1 && !force0;

   // Streak of port-1 grants that starved a waiting port 0; any other
   // arbitration outcome restarts the streak.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak <= 4'd0;
      end else if (state == IDLE && take) begin
         if (pick1 && bif.req0) begin
            streak <= streak + 4'd1;
         end else begin
            streak <= 4'd0;
         end
      end
   end
`else
   logic [3:0] unused_fair;

   assign pick1       = bif.req1;
   assign unused_fair = 4'(FAIR_LIMIT);
`endif

   // Bus cycle sequencer. Outputs are loaded on the edge that enters the
   // state in which they must be visible, which keeps every output a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         gnt          <= 1'b0;
         lrw          <= 1'b0;
         ldtw         <= 16'h0000;
         wcnt         <= 8'd0;
         bif.ack0     <= 1'b0;
         bif.ack1     <= 1'b0;
         bif.dtr0     <= 16'h0000;
         bif.dtr1     <= 16'h0000;
         bif.bus_err  <= 1'b0;
         bif.bus_adr  <= 20'h00000;
         bif.bus_ale  <= 1'b0;
         bif.bus_rd_n <= 1'b1;
         bif.bus_wr_n <= 1'b1;
         bif.bus_dout <= 16'h0000;
         bif.bus_oe   <= 1'b0;
      end else begin
         bif.ack0    <= 1'b0;
         bif.ack1    <= 1'b0;
         bif.bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  gnt         <= pick1;
                  lrw         <= pick1 ? bif.rw1  : bif.rw0;
                  ldtw        <= pick1 ? bif.dtw1 : bif.dtw0;
                  bif.bus_adr <= pick1 ? bif.adr1 : bif.adr0;
                  bif.bus_ale <= 1'b1;
                  state       <= T1;
               end
            end
            T1: begin
               bif.bus_ale <= 1'b0;
               if (lrw) begin
                  bif.bus_rd_n <= 1'b0;
               end else begin
                  bif.bus_wr_n <= 1'b0;
                  bif.bus_oe   <= 1'b1;
                  bif.bus_dout <= ldtw;
               end
               state <= T2;
            end
            T2: begin
               state <= T3;
            end
            T3: begin
               if (bif.bus_ready || tmo) begin
                  bif.bus_rd_n <= 1'b1;
                  bif.bus_wr_n <= 1'b1;
                  bif.bus_oe   <= 1'b0;
                  bif.bus_err  <= tmo;
                  if (gnt) begin
                     bif.ack1 <= 1'b1;
                     if (lrw) bif.dtr1 <= rdata;
                  end else begin
                     bif.ack0 <= 1'b1;
                     if (lrw) bif.dtr0 <= rdata;
                  end
                  state <= T4;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            T4: begin
               wcnt  <= 8'd0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_biu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_biu_sequencer
// Directed bench for biu_sequencer (WAIT_MAX=15, FAIR_LIMIT=4). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so a value seen there is what the previous edge registered.
// Expected grant order follows BIU_FAIR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_biu_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   biu_sequencer_if bif();

   biu_sequencer #(
      .WAIT_MAX   (15),
      .FAIR_LIMIT (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   int compared   = 0;
   int mismatched = 0;
   int ackAt;
   int acks;
   int otherAcks;
   int strobeLow;
   int badDrive;
   int errCount;
   int nAcks;
   logic        errAt;
   logic [15:0] dtrAt;
   logic        grants   [10];
   logic        expGrant [10];
   logic        lastPort;
   logic        gotAck;

   // One clock step; returns just after the rising edge.
   task tick;
      @(posedge clk);
      #1;
   endtask

   // Present (or withdraw) a request on one port.
   task applyStimulus(input int port, input logic req, input logic rw,
                      input logic [19:0] adr, input logic [15:0] dtw);
      if (port == 0) begin
         bif.req0 = req;
         bif.rw0  = rw;
         bif.adr0 = adr;
         bif.dtw0 = dtw;
      end else begin
         bif.req1 = req;
         bif.rw1  = rw;
         bif.adr1 = adr;
         bif.dtw1 = dtw;
      end
   endtask

   // Single comparison point for the whole bench.
   task checkOutput(input string tag, input logic [31:0] got,
                    input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      applyStimulus(0, 1'b0, 1'b0, 20'h0, 16'h0);
      applyStimulus(1, 1'b0, 1'b0, 20'h0, 16'h0);
      bif.bus_din   = 16'h0000;
      bif.bus_ready = 1'b1;
      rst_n         = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;

      // ---------------- reset values ----------------
      $display("[TB] reset values");
      checkOutput("rst_ack0",  32'(bif.ack0),     32'd0);
      checkOutput("rst_ack1",  32'(bif.ack1),     32'd0);
      checkOutput("rst_dtr0",  32'(bif.dtr0),     32'd0);
      checkOutput("rst_dtr1",  32'(bif.dtr1),     32'd0);
      checkOutput("rst_err",   32'(bif.bus_err),  32'd0);
      checkOutput("rst_adr",   32'(bif.bus_adr),  32'd0);
      checkOutput("rst_ale",   32'(bif.bus_ale),  32'd0);
      checkOutput("rst_rdn",   32'(bif.bus_rd_n), 32'd1);
      checkOutput("rst_wrn",   32'(bif.bus_wr_n), 32'd1);
      checkOutput("rst_dout",  32'(bif.bus_dout), 32'd0);
      checkOutput("rst_oe",    32'(bif.bus_oe),   32'd0);

      // ---------------- port-0 read, zero wait ----------------
      $display("[TB] port-0 read");
      applyStimulus(0, 1'b1, 1'b1, 20'h00002, 16'h0);
      bif.bus_din = 16'hA5A5;
      tick;
      checkOutput("r0_c1_ale", 32'(bif.bus_ale),  32'd1);
      checkOutput("r0_c1_adr", 32'(bif.bus_adr),  32'h2);
      checkOutput("r0_c1_rdn", 32'(bif.bus_rd_n), 32'd1);
      tick;
      checkOutput("r0_c2_ale", 32'(bif.bus_ale),  32'd0);
      checkOutput("r0_c2_rdn", 32'(bif.bus_rd_n), 32'd0);
      checkOutput("r0_c2_wrn", 32'(bif.bus_wr_n), 32'd1);
      tick;
      checkOutput("r0_c3_rdn", 32'(bif.bus_rd_n), 32'd0);
      checkOutput("r0_c3_ack", 32'(bif.ack0),     32'd0);
      tick;
      checkOutput("r0_c4_ack0", 32'(bif.ack0),     32'd1);
      checkOutput("r0_c4_ack1", 32'(bif.ack1),     32'd0);
      checkOutput("r0_c4_rdn",  32'(bif.bus_rd_n), 32'd1);
      checkOutput("r0_c4_adr",  32'(bif.bus_adr),  32'h2);
      checkOutput("r0_c4_dtr0", 32'(bif.dtr0),     32'hA5A5);
      checkOutput("r0_c4_dtr1", 32'(bif.dtr1),     32'd0);
      checkOutput("r0_c4_err",  32'(bif.bus_err),  32'd0);
      applyStimulus(0, 1'b0, 1'b1, 20'h00002, 16'h0);
      tick;
      checkOutput("r0_c5_ack0", 32'(bif.ack0),     32'd0);

      // ---------------- simultaneous requests ----------------
      $display("[TB] simultaneous requests");
      applyStimulus(0, 1'b1, 1'b1, 20'h00002, 16'h0);
      applyStimulus(1, 1'b1, 1'b1, 20'h00004, 16'h0);
      bif.bus_din = 16'h1234;
      tick;
      checkOutput("both_c1_adr", 32'(bif.bus_adr), 32'h4);
      checkOutput("both_c1_ale", 32'(bif.bus_ale), 32'd1);
      tick;
      tick;
      tick;
      checkOutput("both_c4_ack1", 32'(bif.ack1), 32'd1);
      checkOutput("both_c4_ack0", 32'(bif.ack0), 32'd0);
      checkOutput("both_c4_dtr1", 32'(bif.dtr1), 32'h1234);
      checkOutput("both_c4_dtr0", 32'(bif.dtr0), 32'hA5A5);
      applyStimulus(1, 1'b0, 1'b1, 20'h00004, 16'h0);
      tick;
      checkOutput("both_c5_ale",  32'(bif.bus_ale), 32'd0);
      checkOutput("both_c5_ack1", 32'(bif.ack1),    32'd0);
      bif.bus_din = 16'h5A5A;
      tick;
      checkOutput("both_c6_ale", 32'(bif.bus_ale), 32'd1);
      checkOutput("both_c6_adr", 32'(bif.bus_adr), 32'h2);
      tick;
      tick;
      tick;
      checkOutput("both_c9_ack0", 32'(bif.ack0), 32'd1);
      checkOutput("both_c9_dtr0", 32'(bif.dtr0), 32'h5A5A);
      checkOutput("both_c9_dtr1", 32'(bif.dtr1), 32'h1234);
      applyStimulus(0, 1'b0, 1'b1, 20'h00002, 16'h0);
      tick;

      // ---------------- port-1 write with three wait states ----------------
      $display("[TB] port-1 write with waits");
      applyStimulus(1, 1'b1, 1'b0, 20'h12345, 16'h0003);
      ackAt = 0; acks = 0; otherAcks = 0; strobeLow = 0; badDrive = 0;
      for (int i = 1; i <= 10; i++) begin
         tick;
         if (i == 3) bif.bus_ready = 1'b0;
         if (i == 6) bif.bus_ready = 1'b1;
         if (bif.bus_wr_n == 1'b0) begin
            strobeLow++;
            if (!(bif.bus_oe == 1'b1 && bif.bus_dout == 16'h0003)) badDrive++;
         end
         if (bif.bus_rd_n == 1'b0) badDrive++;
         if (bif.ack1) begin
            acks++;
            ackAt = i;
            applyStimulus(1, 1'b0, 1'b0, 20'h12345, 16'h0003);
         end
         if (bif.ack0) otherAcks++;
      end
      checkOutput("wr_wrn_low",  32'(strobeLow), 32'd5);
      checkOutput("wr_drive",    32'(badDrive),  32'd0);
      checkOutput("wr_acks",     32'(acks),      32'd1);
      checkOutput("wr_ack_at",   32'(ackAt),     32'd7);
      checkOutput("wr_ack0",     32'(otherAcks), 32'd0);
      checkOutput("wr_dtr1",     32'(bif.dtr1),  32'h1234);
      checkOutput("wr_dtr0",     32'(bif.dtr0),  32'h5A5A);
      checkOutput("wr_oe_idle",  32'(bif.bus_oe), 32'd0);

      // ---------------- port-0 read timeout ----------------
      $display("[TB] port-0 read timeout");
      bif.bus_ready = 1'b0;
      bif.bus_din   = 16'h7777;
      applyStimulus(0, 1'b1, 1'b1, 20'h0ABCD, 16'h0);
      ackAt = 0; strobeLow = 0; errCount = 0; errAt = 1'b0; dtrAt = 16'h0;
      for (int i = 1; i <= 30; i++) begin
         tick;
         if (bif.bus_rd_n == 1'b0) strobeLow++;
         if (bif.bus_err) errCount++;
         if (bif.ack0 && ackAt == 0) begin
            ackAt = i;
            errAt = bif.bus_err;
            dtrAt = bif.dtr0;
            applyStimulus(0, 1'b0, 1'b1, 20'h0ABCD, 16'h0);
         end
      end
      checkOutput("to_ack_at",  32'(ackAt),     32'd18);
      checkOutput("to_rdn_low", 32'(strobeLow), 32'd16);
      checkOutput("to_err",     32'(errAt),     32'd1);
      checkOutput("to_err_cnt", 32'(errCount),  32'd1);
      checkOutput("to_dtr0",    32'(dtrAt),     32'hFFFF);
      checkOutput("to_dtr1",    32'(bif.dtr1),  32'h1234);

      bif.bus_ready = 1'b1;
      bif.bus_din   = 16'h0F0F;
      applyStimulus(0, 1'b1, 1'b1, 20'h0ABCE, 16'h0);
      tick;
      tick;
      tick;
      tick;
      checkOutput("after_to_ack0", 32'(bif.ack0),    32'd1);
      checkOutput("after_to_err",  32'(bif.bus_err), 32'd0);
      checkOutput("after_to_dtr0", 32'(bif.dtr0),    32'h0F0F);
      applyStimulus(0, 1'b0, 1'b1, 20'h0ABCE, 16'h0);
      tick;

      // ---------------- continuous contention ----------------
      $display("[TB] continuous contention");
      for (int k = 0; k < 10; k++) begin
`ifdef BIU_FAIR_EN
         expGrant[k] = (k == 4 || k == 9) ? 1'b0 : 1'b1;
`else
         expGrant[k] = 1'b1;
`endif
         grants[k] = 1'bx;
      end
      applyStimulus(0, 1'b1, 1'b0, 20'h00100, 16'h1111);
      applyStimulus(1, 1'b1, 1'b0, 20'h00200, 16'h2222);
      nAcks = 0;
      for (int i = 0; i < 80 && nAcks < 10; i++) begin
         tick;
         if (bif.ack0 || bif.ack1) begin
            grants[nAcks] = bif.ack1;
            nAcks++;
         end
      end
      applyStimulus(1, 1'b0, 1'b0, 20'h00200, 16'h2222);
      checkOutput("fair_acks", 32'(nAcks), 32'd10);
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("grant%0d", k), 32'(grants[k]), 32'(expGrant[k]));
      end
      gotAck = 1'b0;
      lastPort = 1'b1;
      for (int i = 0; i < 10 && !gotAck; i++) begin
         tick;
         if (bif.ack0 || bif.ack1) begin
            gotAck   = 1'b1;
            lastPort = bif.ack1;
         end
      end
      checkOutput("req1_drop_ack",  32'(gotAck),   32'd1);
      checkOutput("req1_drop_port", 32'(lastPort), 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 20'h00100, 16'h1111);
      tick;

      // ---------------- reset during T3 ----------------
      $display("[TB] reset during T3");
      bif.bus_din = 16'hBEEF;
      applyStimulus(1, 1'b1, 1'b1, 20'h0F00D, 16'h0);
      tick;
      tick;
      tick;
      checkOutput("rst_t3_rdn", 32'(bif.bus_rd_n), 32'd0);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checkOutput("rst_t3_ack1", 32'(bif.ack1),     32'd0);
      checkOutput("rst_t3_rdn2", 32'(bif.bus_rd_n), 32'd1);
      checkOutput("rst_t3_adr",  32'(bif.bus_adr),  32'd0);
      checkOutput("rst_t3_dtr0", 32'(bif.dtr0),     32'd0);
      checkOutput("rst_t3_dtr1", 32'(bif.dtr1),     32'd0);
      checkOutput("rst_t3_ale",  32'(bif.bus_ale),  32'd0);
      ackAt = 0; acks = 0; dtrAt = 16'h0;
      for (int i = 1; i <= 6; i++) begin
         tick;
         if (bif.ack1) begin
            acks++;
            ackAt = i;
            dtrAt = bif.dtr1;
            applyStimulus(1, 1'b0, 1'b1, 20'h0F00D, 16'h0);
         end
      end
      checkOutput("post_rst_acks",  32'(acks),  32'd1);
      checkOutput("post_rst_ackat", 32'(ackAt), 32'd4);
      checkOutput("post_rst_dtr1",  32'(dtrAt), 32'hBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
